// File: rtl/vga_timing_ctrl_pkg.sv
// Shared types and default 640x480@60 timing constants for the VGA raster timing block.
package vga_timing_ctrl_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_CLK_DIV   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Divider register width; a divide-by-1 still needs a 1-bit register.
    function automatic int div_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/counterN_en.sv
// Enabled mod-(ULIMIT+1) counter with synchronous clear and asynchronous active-low reset.
module counterN_en #(
    parameter int WIDTH  = 10,
    parameter int ULIMIT = 799
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_sclr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_cnt
);

    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(ULIMIT);

    logic [WIDTH-1:0] cnt_reg;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_reg <= '0;
        end else if (i_sclr) begin
            cnt_reg <= '0;
        end else if (i_en) begin
            cnt_reg <= (cnt_reg == LIMIT) ? '0 : cnt_reg + 1'b1;
        end
    end

    assign o_cnt = cnt_reg;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: pixel-tick divider, chained h/v counters, sync/DE decode and a
// run/stop controller that only ever stops on a frame boundary.
module vga_timing_ctrl
    import vga_timing_ctrl_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int HW        = 10,
    parameter int VW        = 10
) (
    input  logic          clk,
    input  logic          i_rst_n,
    input  logic          i_run,
    output logic          o_running,
    output logic          o_pix_tick,
    output logic [HW-1:0] o_hcnt,
    output logic [VW-1:0] o_vcnt,
    output logic          o_de,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_line_end,
    output logic          o_frame_end
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = div_width(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST    = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_END   = HW'(H_VISIBLE);
    localparam logic [VW-1:0] V_VIS_END   = VW'(V_VISIBLE);
    localparam logic [HW-1:0] H_SYNC_BEG  = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_END  = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_SYNC_BEG  = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_END  = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    state_t          state_reg;
    logic [DW-1:0]   div_reg;
    logic [HW-1:0]   hcnt;
    logic [VW-1:0]   vcnt;
    logic            running;
    logic            pix_tick;
    logic            line_end;
    logic            frame_end;

    assign running   = (state_reg != ST_IDLE);
    assign pix_tick  = running && (div_reg == DIV_LAST);
    assign line_end  = pix_tick && (hcnt == H_LAST);
    assign frame_end = line_end && (vcnt == V_LAST);

    // A stop request drains to the end of the current frame; re-raising run cancels it.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_run) state_reg <= ST_RUN;
                end
                ST_RUN: begin
                    if (!i_run) state_reg <= frame_end ? ST_IDLE : ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (i_run)          state_reg <= ST_RUN;
                    else if (frame_end) state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_reg <= '0;
        end else if (!running || div_reg == DIV_LAST) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + 1'b1;
        end
    end

    counterN_en #(
        .WIDTH  (HW),
        .ULIMIT (H_TOTAL - 1)
    ) u_hcnt (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_sclr  (!running),
        .i_en    (pix_tick),
        .o_cnt   (hcnt)
    );

    counterN_en #(
        .WIDTH  (VW),
        .ULIMIT (V_TOTAL - 1)
    ) u_vcnt (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_sclr  (!running),
        .i_en    (line_end),
        .o_cnt   (vcnt)
    );

    // Everything is gated by the state so stale counter contents never leak out in IDLE.
    assign o_running   = running;
    assign o_pix_tick  = pix_tick;
    assign o_hcnt      = running ? hcnt : '0;
    assign o_vcnt      = running ? vcnt : '0;
    assign o_de        = running && (hcnt < H_VIS_END) && (vcnt < V_VIS_END);
    assign o_hsync     = !(running && (hcnt >= H_SYNC_BEG) && (hcnt < H_SYNC_END));
    assign o_vsync     = !(running && (vcnt >= V_SYNC_BEG) && (vcnt < V_SYNC_END));
    assign o_line_end  = line_end;
    assign o_frame_end = frame_end;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl with a tiny 8x6 raster (H 4/1/2/1, V 3/1/1/1, CLK_DIV=2).
module tb_vga_timing_ctrl;

    localparam int HW = 10;
    localparam int VW = 10;

    logic          clk = 1'b0;
    logic          i_rst_n;
    logic          i_run;
    logic          o_running;
    logic          o_pix_tick;
    logic [HW-1:0] o_hcnt;
    logic [VW-1:0] o_vcnt;
    logic          o_de;
    logic          o_hsync;
    logic          o_vsync;
    logic          o_line_end;
    logic          o_frame_end;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vga_timing_ctrl #(
        .H_VISIBLE (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
        .V_VISIBLE (3), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
        .CLK_DIV   (2), .HW (HW), .VW (VW)
    ) dut (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_run       (i_run),
        .o_running   (o_running),
        .o_pix_tick  (o_pix_tick),
        .o_hcnt      (o_hcnt),
        .o_vcnt      (o_vcnt),
        .o_de        (o_de),
        .o_hsync     (o_hsync),
        .o_vsync     (o_vsync),
        .o_line_end  (o_line_end),
        .o_frame_end (o_frame_end)
    );

    // Observation vector: {running, tick, de, hsync, vsync, line_end, frame_end, hcnt, vcnt}
    logic [26:0] obs;
    assign obs = {o_running, o_pix_tick, o_de, o_hsync, o_vsync, o_line_end, o_frame_end,
                  o_hcnt, o_vcnt};

    localparam logic [26:0] IDLE_VEC = {7'b0001100, 10'd0, 10'd0};

    function automatic logic [26:0] ev(input logic r, input logic t, input logic d,
                                       input logic hs, input logic vs, input logic le,
                                       input logic fe, input int h, input int v);
        logic [9:0] hh;
        logic [9:0] vv;
        hh = h[9:0];
        vv = v[9:0];
        return {r, t, d, hs, vs, le, fe, hh, vv};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // sel 0: vcnt==val, 1: frame_end, 2: hcnt==3 && vcnt==2
    task automatic wait_cond(input int sel, input int val, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            cyc();
            if ((sel == 0 && o_vcnt == val[VW-1:0]) ||
                (sel == 1 && o_frame_end) ||
                (sel == 2 && o_hcnt == 10'd3 && o_vcnt == 10'd2)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_run   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            tests++;
            if (obs !== IDLE_VEC) begin
                fails++;
                $display("FAIL reset_hold[%0d]: got %h expected %h", i, obs, IDLE_VEC);
            end
        end
        i_rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            tests++;
            if (obs !== IDLE_VEC) begin
                fails++;
                $display("FAIL idle_after_release[%0d]: got %h expected %h", i, obs, IDLE_VEC);
            end
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_start_line();
        int h2;
        int v2;
        i_run = 1'b1;
        cyc();
        tests++;
        if (obs !== ev(1, 0, 1, 1, 1, 0, 0, 0, 0)) begin
            fails++;
            $display("FAIL start_entry: got %h expected %h", obs, ev(1, 0, 1, 1, 1, 0, 0, 0, 0));
        end
        for (int k = 0; k < 8; k++) begin
            cyc();
            tests++;
            if (obs !== ev(1, 1, k < 4, !(k == 5 || k == 6), 1, k == 7, 0, k, 0)) begin
                fails++;
                $display("FAIL line_tick h=%0d: got %h expected %h", k, obs,
                         ev(1, 1, k < 4, !(k == 5 || k == 6), 1, k == 7, 0, k, 0));
            end
            h2 = (k + 1) % 8;
            v2 = (k == 7) ? 1 : 0;
            cyc();
            tests++;
            if (obs !== ev(1, 0, h2 < 4, !(h2 == 5 || h2 == 6), 1, 0, 0, h2, v2)) begin
                fails++;
                $display("FAIL line_gap h=%0d: got %h expected %h", k, obs,
                         ev(1, 0, h2 < 4, !(h2 == 5 || h2 == 6), 1, 0, 0, h2, v2));
            end
        end
        $display("[TB] test_start_line done");
    endtask

    task automatic test_frame();
        int h2;
        int v2;
        int vs_low;
        int n;
        vs_low = 0;
        for (int v = 1; v < 6; v++) begin
            for (int h = 0; h < 8; h++) begin
                cyc();
                if (!o_vsync) vs_low++;
                tests++;
                if (obs !== ev(1, 1, h < 4 && v < 3, !(h == 5 || h == 6), v != 4,
                               h == 7, h == 7 && v == 5, h, v)) begin
                    fails++;
                    $display("FAIL frame_tick h=%0d v=%0d: got %h expected %h", h, v, obs,
                             ev(1, 1, h < 4 && v < 3, !(h == 5 || h == 6), v != 4,
                                h == 7, h == 7 && v == 5, h, v));
                end
                h2 = (h + 1) % 8;
                v2 = (h == 7) ? (v + 1) % 6 : v;
                cyc();
                if (!o_vsync) vs_low++;
                tests++;
                if (obs !== ev(1, 0, h2 < 4 && v2 < 3, !(h2 == 5 || h2 == 6), v2 != 4,
                               0, 0, h2, v2)) begin
                    fails++;
                    $display("FAIL frame_gap h=%0d v=%0d: got %h expected %h", h, v, obs,
                             ev(1, 0, h2 < 4 && v2 < 3, !(h2 == 5 || h2 == 6), v2 != 4,
                                0, 0, h2, v2));
                end
            end
        end
        tests++;
        if (vs_low != 16) begin
            fails++;
            $display("FAIL vsync_low_clks: got %0d expected 16", vs_low);
        end
        n = 1;
        while (!o_frame_end && n < 300) begin
            cyc();
            n++;
        end
        tests++;
        if (n != 96) begin
            fails++;
            $display("FAIL frame_length: got %0d clks expected 96", n);
        end
        $display("[TB] test_frame done");
    endtask

    task automatic test_stop_boundary();
        bit ok;
        wait_cond(0, 1, ok);
        i_run = 1'b0;
        wait_cond(1, 0, ok);
        tests++;
        if (!ok || !o_running) begin
            fails++;
            $display("FAIL drain_to_frame_end: got ok=%0d running=%0d expected 1/1", ok, o_running);
        end
        cyc();
        tests++;
        if (obs !== IDLE_VEC) begin
            fails++;
            $display("FAIL stop_idle: got %h expected %h", obs, IDLE_VEC);
        end
        repeat (3) cyc();
        tests++;
        if (obs !== IDLE_VEC) begin
            fails++;
            $display("FAIL stop_idle_hold: got %h expected %h", obs, IDLE_VEC);
        end

        i_run = 1'b1;
        cyc();
        tests++;
        if (obs !== ev(1, 0, 1, 1, 1, 0, 0, 0, 0)) begin
            fails++;
            $display("FAIL restart_from_origin: got %h expected %h", obs, ev(1, 0, 1, 1, 1, 0, 0, 0, 0));
        end
        wait_cond(0, 1, ok);
        i_run = 1'b0;
        wait_cond(0, 3, ok);
        i_run = 1'b1;
        wait_cond(1, 0, ok);
        cyc();
        tests++;
        if (!ok || obs !== ev(1, 0, 1, 1, 1, 0, 0, 0, 0)) begin
            fails++;
            $display("FAIL cancelled_stop_wrap: got ok=%0d %h expected %h", ok, obs,
                     ev(1, 0, 1, 1, 1, 0, 0, 0, 0));
        end
        wait_cond(0, 1, ok);
        tests++;
        if (!ok || !o_running) begin
            fails++;
            $display("FAIL cancelled_stop_continue: got ok=%0d running=%0d expected 1/1", ok, o_running);
        end
        $display("[TB] test_stop_boundary done");
    endtask

    task automatic test_stop_at_frame_end();
        bit ok;
        wait_cond(1, 0, ok);
        i_run = 1'b0;
        cyc();
        tests++;
        if (!ok || obs !== IDLE_VEC) begin
            fails++;
            $display("FAIL coincident_stop: got ok=%0d %h expected %h", ok, obs, IDLE_VEC);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            tests++;
            if (o_pix_tick !== 1'b0) begin
                fails++;
                $display("FAIL no_extra_tick[%0d]: got %0d expected 0", i, o_pix_tick);
            end
        end
        $display("[TB] test_stop_at_frame_end done");
    endtask

    task automatic test_async_reset();
        bit ok;
        i_run = 1'b1;
        wait_cond(2, 0, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL reach_h3_v2: got timeout expected position reached");
        end
        #1 i_rst_n = 1'b0;
        #1;
        tests++;
        if (obs !== IDLE_VEC) begin
            fails++;
            $display("FAIL async_reset_idle: got %h expected %h", obs, IDLE_VEC);
        end
        cyc();
        i_rst_n = 1'b1;
        cyc();
        tests++;
        if (obs !== ev(1, 0, 1, 1, 1, 0, 0, 0, 0)) begin
            fails++;
            $display("FAIL post_reset_entry: got %h expected %h", obs, ev(1, 0, 1, 1, 1, 0, 0, 0, 0));
        end
        cyc();
        tests++;
        if (obs !== ev(1, 1, 1, 1, 1, 0, 0, 0, 0)) begin
            fails++;
            $display("FAIL post_reset_first_tick: got %h expected %h", obs, ev(1, 1, 1, 1, 1, 0, 0, 0, 0));
        end
        cyc();
        tests++;
        if (obs !== ev(1, 0, 1, 1, 1, 0, 0, 1, 0)) begin
            fails++;
            $display("FAIL post_reset_h1: got %h expected %h", obs, ev(1, 0, 1, 1, 1, 0, 0, 1, 0));
        end
        $display("[TB] test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_start_line();
        test_frame();
        test_stop_boundary();
        test_stop_at_frame_end();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
